// File: rtl/fetch_queue_pkg.sv
// Shared pipeline constants and the fetch-to-decode queue entry format.
package fetch_queue_pkg;

    typedef enum logic [2:0] {
        STG_FE = 3'd0,
        STG_DE = 3'd1,
        STG_EX = 3'd2,
        STG_MM = 3'd3,
        STG_WB = 3'd4
    } pipe_stage_e;

    localparam int unsigned NPC_W = 64;
    localparam int unsigned IR_W  = 32;

    // addi x0,x0,0 presented to decode while the queue is empty
    localparam logic [IR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [NPC_W-1:0] npc;
        logic [IR_W-1:0]  ir;
    } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Fetch-queue entry array: one synchronous write port, one combinational read port.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  fq_entry_t       wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output fq_entry_t       rdata_o
);

    fq_entry_t mem_q [DEPTH];

    // Contents are masked by the owner's occupancy count, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction queue between fetch and decode; redirect or reset empties it.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    // Widths must match the shared fq_entry_t layout.
    parameter int unsigned NPC_W = fetch_queue_pkg::NPC_W,
    parameter int unsigned IR_W  = fetch_queue_pkg::IR_W
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       FE_V,
    input  logic [NPC_W-1:0]           FE_NPC,
    input  logic [IR_W-1:0]            FE_IR,
    output logic                       FQ_FULL,
    input  logic                       DE_STALL,
    input  logic                       FLUSH,
    output logic                       DE_V,
    output logic [NPC_W-1:0]           DE_NPC,
    output logic [IR_W-1:0]            DE_IR,
    output logic [$clog2(DEPTH+1)-1:0] FQ_COUNT
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic      full_c;
    logic      empty_c;
    logic      push_c;
    logic      pop_c;
    fq_entry_t wr_entry_c;
    fq_entry_t head_c;

    // Full check is strict: a same-cycle pop never frees a slot for a push.
    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign push_c  = FE_V & ~full_c & ~FLUSH;
    assign pop_c   = ~empty_c & ~DE_STALL & ~FLUSH;

    assign wr_entry_c.npc = FE_NPC;
    assign wr_entry_c.ir  = FE_IR;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (FLUSH) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
            end
            if (pop_c) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            end
            if (push_c && !pop_c) begin
                count_d = CNT_W'(count_q + 1'b1);
            end else if (!push_c && pop_c) begin
                count_d = CNT_W'(count_q - 1'b1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_storage (
        .clk_i   (CLK),
        .we_i    (push_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_c)
    );

    // Outputs depend only on registered state; empty presents a NOP with zero PC.
    assign DE_V     = ~empty_c;
    assign DE_NPC   = empty_c ? '0 : head_c.npc;
    assign DE_IR    = empty_c ? NOP_INSTR : head_c.ir;
    assign FQ_FULL  = full_c;
    assign FQ_COUNT = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a FIFO scoreboard of pushed entries.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        CLK;
    logic        RESET;
    logic        FE_V;
    logic [63:0] FE_NPC;
    logic [31:0] FE_IR;
    logic        FQ_FULL;
    logic        DE_STALL;
    logic        FLUSH;
    logic        DE_V;
    logic [63:0] DE_NPC;
    logic [31:0] DE_IR;
    logic [2:0]  FQ_COUNT;

    int checks = 0;
    int errors = 0;

    logic [63:0] sb_npc [$];
    logic [31:0] sb_ir  [$];
    logic [31:0] popped [$];

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .FE_V     (FE_V),
        .FE_NPC   (FE_NPC),
        .FE_IR    (FE_IR),
        .FQ_FULL  (FQ_FULL),
        .DE_STALL (DE_STALL),
        .FLUSH    (FLUSH),
        .DE_V     (DE_V),
        .DE_NPC   (DE_NPC),
        .DE_IR    (DE_IR),
        .FQ_COUNT (FQ_COUNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: check outputs against the scoreboard, drive inputs, advance one edge.
    task automatic cycle(input logic fe_v, input logic [63:0] npc, input logic [31:0] ir,
                         input logic stall, input logic flush, input logic rst);
        int  sz;
        logic do_push, do_pop;
        sz = sb_ir.size();
        chk("count", 64'(FQ_COUNT), 64'(sz));
        chk("full",  64'(FQ_FULL),  64'(sz == DEPTH));
        chk("de_v",  64'(DE_V),     64'(sz != 0));
        if (sz != 0) begin
            chk("de_ir",  64'(DE_IR), 64'(sb_ir[0]));
            chk("de_npc", DE_NPC,     sb_npc[0]);
        end else begin
            chk("de_ir_nop", 64'(DE_IR), 64'(NOP));
            chk("de_npc_0",  DE_NPC,     64'h0);
        end
        FE_V = fe_v; FE_NPC = npc; FE_IR = ir;
        DE_STALL = stall; FLUSH = flush; RESET = rst;
        if (flush || rst) begin
            sb_ir.delete();
            sb_npc.delete();
        end else begin
            do_push = fe_v && (sz < DEPTH);
            do_pop  = (sz != 0) && !stall;
            if (do_pop) begin
                popped.push_back(DE_IR);
                void'(sb_ir.pop_front());
                void'(sb_npc.pop_front());
            end
            if (do_push) begin
                sb_ir.push_back(ir);
                sb_npc.push_back(npc);
            end
        end
        @(posedge CLK);
        @(negedge CLK);
        FE_V = 1'b0; FLUSH = 1'b0; RESET = 1'b0;
    endtask

    task automatic idle(input logic stall);
        cycle(1'b0, 64'h0, 32'h0, stall, 1'b0, 1'b0);
    endtask

    initial begin
        FE_V = 1'b0; FE_NPC = '0; FE_IR = '0; DE_STALL = 1'b0; FLUSH = 1'b0;
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;

        // Reset then idle
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Three pushes under stall, then drain
        cycle(1'b1, 64'h4, 32'hA, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'h8, 32'hB, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'hC, 32'hC, 1'b1, 1'b0, 1'b0);
        chk("count_3", 64'(FQ_COUNT), 64'd3);
        popped.delete();
        for (int i = 0; i < 4; i++) idle(1'b0);
        chk("drain_n", 64'(popped.size()), 64'd3);
        if (popped.size() == 3) begin
            chk("drain_0", 64'(popped[0]), 64'hA);
            chk("drain_1", 64'(popped[1]), 64'hB);
            chk("drain_2", 64'(popped[2]), 64'hC);
        end
        chk("drained_v", 64'(DE_V), 64'd0);

        // Fill to DEPTH, a fifth push must be dropped
        for (int i = 1; i <= 4; i++)
            cycle(1'b1, 64'(32'h100 + 4 * i), 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
        chk("full_1", 64'(FQ_FULL), 64'd1);
        cycle(1'b1, 64'h200, 32'h105, 1'b1, 1'b0, 1'b0);
        chk("full_hold", 64'(FQ_COUNT), 64'd4);
        popped.delete();
        for (int i = 0; i < 5; i++) idle(1'b0);
        chk("fill_n", 64'(popped.size()), 64'd4);
        for (int i = 0; i < popped.size(); i++)
            chk("fill_order", 64'(popped[i]), 64'(32'h101 + 32'(i)));

        // Full with fetch holding: pop frees a slot, push lands one cycle later
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 64'(32'h300 + i), 32'h300 + 32'(i), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'h3F0, 32'h3F0, 1'b0, 1'b0, 1'b0);
        chk("bubble_cnt", 64'(FQ_COUNT), 64'd3);
        chk("bubble_full", 64'(FQ_FULL), 64'd0);
        cycle(1'b1, 64'h3F0, 32'h3F0, 1'b1, 1'b0, 1'b0);
        chk("refill_full", 64'(FQ_FULL), 64'd1);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Steady stream with two entries in flight, pointers wrap
        cycle(1'b1, 64'h400, 32'h400, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'h404, 32'h401, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i < 12; i++) begin
            cycle(1'b1, 64'(32'h400 + 4 * i), 32'h400 + 32'(i), 1'b0, 1'b0, 1'b0);
            chk("stream_cnt", 64'(FQ_COUNT), 64'd2);
        end
        for (int i = 0; i < 3; i++) idle(1'b0);

        // Flush with count 3 and a simultaneous push
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 64'(32'h500 + i), 32'h500 + 32'(i), 1'b1, 1'b0, 1'b0);
        popped.delete();
        cycle(1'b1, 64'hDEAD, 32'hDEAD, 1'b0, 1'b1, 1'b0);
        chk("flush_cnt", 64'(FQ_COUNT), 64'd0);
        chk("flush_v", 64'(DE_V), 64'd0);
        idle(1'b0);
        chk("flush_nopop", 64'(popped.size()), 64'd0);

        // Flush while full
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 64'(32'h600 + i), 32'h600 + 32'(i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("flush_full", 64'(FQ_FULL), 64'd0);

        // Reset mid-stream with count 2 and no stall
        cycle(1'b1, 64'h700, 32'h700, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 64'h704, 32'h701, 1'b1, 1'b0, 1'b0);
        popped.delete();
        cycle(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_ir", 64'(DE_IR), 64'(NOP));
        chk("rst_cnt", 64'(FQ_COUNT), 64'd0);
        chk("rst_nopop", 64'(popped.size()), 64'd0);
        idle(1'b0);

        // Queue still works after reset
        cycle(1'b1, 64'h800, 32'h800, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. It decouples instruction delivery from decode dependency stalls. Fetch pushes {NPC, IR} pairs in order. Decode pops from the head whenever it is not stalled. A control-flow redirect from writeback empties the queue.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- NPC_W, 64, width of the next-PC field
- IR_W, 32, width of the instruction field

Ports:
- CLK  in  1  core clock; all state updates on the rising edge
- RESET  in  1  reset, synchronous and active-high
- FE_V  in  1  fetch presents a valid instruction this cycle
- FE_NPC  in  NPC_W  next-PC of the presented instruction
- FE_IR  in  IR_W  presented instruction word
- FQ_FULL  out  1  queue full; fetch must hold its PC and present the same instruction again
- DE_STALL  in  1  decode cannot accept this cycle (dependency stall or branch stall)
- FLUSH  in  1  redirect (writeback PC_MUX); discard every entry
- DE_V  out  1  head entry valid toward decode
- DE_NPC  out  NPC_W  head entry next-PC
- DE_IR  out  IR_W  head entry instruction
- FQ_COUNT  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: circular buffer of DEPTH entries, each holding {NPC, IR}.
- Pointers: head (rd_ptr) and tail (wr_ptr), each $clog2(DEPTH) bits, plus count register.
  - Pointers wrap modulo DEPTH with natural overflow.
- push = FE_V & ~FQ_FULL & ~FLUSH.
  - Writes entry[wr_ptr].
  - wr_ptr increments.
- pop = DE_V & ~DE_STALL & ~FLUSH.
  - rd_ptr increments.
- Occupancy update:
  - count += push − pop.
  - push and pop in the same cycle leave count unchanged.
- FQ_FULL = (count == DEPTH). This is a strict full check: no push occurs while full, even if a pop happens in the same cycle.
- Empty queue (count == 0):
  - DE_V = 0.
  - DE_IR = 32'h0000_0013 (NOP, addi x0,x0,0).
  - DE_NPC = 0.
- Non-empty queue: DE_V = 1, DE_NPC = entry[rd_ptr].NPC, DE_IR = entry[rd_ptr].IR.
- FLUSH:
  - Next edge sets count = 0, rd_ptr = wr_ptr = 0.
  - Any push or pop in that cycle is ignored.
  - FLUSH takes priority over every other event.
- RESET has the same effect as FLUSH.
  - Storage contents are don't-care; they are masked by count.
- Ordering: strictly FIFO; no reordering, no bypass.

## Timing
- Reset values:
  - DE_V = 0, DE_NPC = 0, DE_IR = NOP.
  - FQ_FULL = 0, FQ_COUNT = 0.
- DE_* and FQ_FULL are combinational functions of registered state only. There is no combinational path from FE_* or DE_STALL to any output.
- Latency: an instruction pushed at edge N into an empty queue appears on DE_* in cycle N+1.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Full queue:
  - A pop at edge N drops FQ_FULL in cycle N+1.
  - Fetch's next push lands at edge N+1, giving a one-cycle bubble.
- Empty queue with DE_STALL high: no pop and no underflow; count stays 0.
- FLUSH while full: FQ_FULL = 0 in the next cycle.
- RESET or FLUSH asserted mid-stream: the state after the edge is identical to the post-reset state.

## Structure
- Shared pipeline package (alongside the existing stage constants) holds:
  - NOP_INSTR = 32'h0000_0013.
  - NPC_W, IR_W.
  - fq_entry_t, a packed struct {NPC, IR}.
- Sub-module fq_storage: DEPTH×fq_entry_t register array with one write port and one combinational read port; no reset.
- fetch_queue owns the pointers, count, push/pop/flush logic and output muxing.
- Integration: sits between fetch (FE_*) and decode_stage.
  - DE_* replace fetch's direct decode outputs.
  - DE_STALL is V_DEP_STALL | V_DE_FE_BR_STALL.
  - FLUSH is OUT_FE_PC_MUX.

## Test plan
- Reset, then idle 3 cycles: DE_V = 0, DE_IR = 32'h13, FQ_COUNT = 0, FQ_FULL = 0 throughout.
- Push NPC 0x4/IR 0xA, NPC 0x8/IR 0xB, NPC 0xC/IR 0xC on consecutive cycles with DE_STALL = 1:
  - FQ_COUNT reaches 3.
  - After DE_STALL drops, DE_IR reads 0xA, 0xB, 0xC on consecutive cycles, then DE_V = 0.
- Fill to DEPTH = 4 with DE_STALL = 1: FQ_FULL = 1; a 5th FE_V is not stored. Release the stall: the pop sequence is exactly entries 1–4.
- Continuous push and pop for 10 cycles: pointers wrap; FQ_COUNT stays constant; DE_IR order matches push order.
- FLUSH asserted with count = 3 and FE_V = 1 in the same cycle: next cycle count = 0, DE_V = 0, and the FE instruction is discarded.
- RESET asserted with count = 2 and DE_STALL = 0: next cycle all outputs hold their reset values; no pop is observed.
